// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath defaults and the signed saturate helper
package cnn_pkg;

  localparam int FMAP_W_DEF = 8;
  localparam int FMAP_H_DEF = 8;
  localparam int DIN_W_DEF  = 14;
  localparam int DOUT_W_DEF = 12;

  // Clamp x into the range of a w-bit two's complement value.
  function automatic int sat_signed(input int x, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/conv2_relu_pool.sv
// rtl/conv2_relu_pool.sv - streaming 2x2 max-pool of conv2 samples, optional ReLU (CONV2_POOL_RELU_EN)
module conv2_relu_pool
  import cnn_pkg::*;
#(
  parameter int FMAP_W = FMAP_W_DEF,
  parameter int FMAP_H = FMAP_H_DEF,
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     valid_in,
  input  logic signed [DIN_W-1:0]  data_in,
  output logic                     valid_out,
  output logic signed [DOUT_W-1:0] data_out,
  output logic                     frame_done
);

  localparam int CW   = $clog2(FMAP_W);
  localparam int RW   = $clog2(FMAP_H);
  localparam int LB_N = FMAP_W / 2;
  localparam logic [CW-1:0] COL_LAST = CW'(FMAP_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_H - 1);

  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic signed [DIN_W-1:0]   pair_q, pair_d;
  logic signed [DIN_W-1:0]   lb_q [LB_N];
  logic signed [DIN_W-1:0]   lb_d [LB_N];
  logic                      valid_q, valid_d;
  logic signed [DOUT_W-1:0]  dout_q, dout_d;
  logic                      done_q, done_d;

  logic signed [DIN_W-1:0]   p;
  logic signed [DIN_W-1:0]   pm;
  logic signed [DIN_W-1:0]   m;
  logic [CW-2:0]             lb_idx;
  logic signed [31:0]        sat_v;

  always_comb begin
`ifdef CONV2_POOL_RELU_EN
    p = data_in[DIN_W-1] ? '0 : data_in;
`else
    p = data_in;
`endif
    lb_idx = col_q[CW-1:1];
    pm     = (pair_q > p) ? pair_q : p;
    m      = (lb_q[lb_idx] > pm) ? lb_q[lb_idx] : pm;
    sat_v  = sat_signed(32'(m), DOUT_W);

    col_d   = col_q;
    row_d   = row_q;
    pair_d  = pair_q;
    lb_d    = lb_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    dout_d  = dout_q;

    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      pair_d = '0;
    end else if (valid_in) begin
      // Even col parks the left pixel; odd col folds the horizontal pair.
      if (!col_q[0]) begin
        pair_d = p;
      end else if (!row_q[0]) begin
        lb_d[lb_idx] = pm;
      end else begin
        valid_d = 1'b1;
        dout_d  = sat_v[DOUT_W-1:0];
        done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < LB_N; i++) begin
        lb_q[i] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      lb_q    <= lb_d;
    end
  end

  assign valid_out  = valid_q;
  assign data_out   = dout_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_conv2_relu_pool.sv
// tb/tb_conv2_relu_pool.sv - scoreboard bench for conv2_relu_pool against a 2x2-block reference model
module tb_conv2_relu_pool;

  localparam int W      = 8;
  localparam int H      = 8;
  localparam int DIN_W  = 14;
  localparam int DOUT_W = 12;
  localparam int OMAX   = (1 << (DOUT_W - 1)) - 1;
  localparam int OMIN   = -(1 << (DOUT_W - 1));

  logic                     clk;
  logic                     rst_n;
  logic                     clear;
  logic                     valid_in;
  logic signed [DIN_W-1:0]  data_in;
  logic                     valid_out;
  logic signed [DOUT_W-1:0] data_out;
  logic                     frame_done;

  conv2_relu_pool #(
    .FMAP_W(W), .FMAP_H(H), .DIN_W(DIN_W), .DOUT_W(DOUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out), .frame_done(frame_done)
  );

  typedef struct {
    int     data;
    bit     last;
    longint cyc;
  } exp_t;

  exp_t   q[$];
  int     tests_run    = 0;
  int     tests_failed = 0;
  longint cyc          = 0;
  int     last_data    = 0;
  int     pix [H][W];
  int     mr = 0;
  int     mc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: keep the frame as a 2-D array; each 2x2 block completes at its bottom-right pixel.
  task automatic model_pixel(input int v);
    int a, b, c, d, m;
`ifdef CONV2_POOL_RELU_EN
    if (v < 0) v = 0;
`endif
    pix[mr][mc] = v;
    if ((mr % 2 == 1) && (mc % 2 == 1)) begin
      a = pix[mr-1][mc-1]; b = pix[mr-1][mc]; c = pix[mr][mc-1]; d = pix[mr][mc];
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (m > OMAX) m = OMAX;
      if (m < OMIN) m = OMIN;
      q.push_back('{data: m, last: (mr == H-1 && mc == W-1), cyc: cyc + 1});
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr + 1) % H;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      valid_in = 1'b0;
      clear    = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input int v, input int gap);
    logic signed [DIN_W-1:0] s;
    idle(gap);
    s        = v[DIN_W-1:0];
    valid_in = 1'b1;
    clear    = 1'b0;
    data_in  = s;
    model_pixel(int'(s));
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic ramp_pixels(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      send((i / W) * 8 + (i % W), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic const_frame(input int v);
    for (int i = 0; i < W * H; i++) send(v, 0);
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    valid_in = 1'b1;
    data_in  = 14'sd1234;
    @(posedge clk); #1;
    clear    = 1'b0;
    valid_in = 1'b0;
    mr = 0;
    mc = 0;
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    clear    = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_frame_done", frame_done, 0);
    q.delete();
    last_data = 0;
    mr = 0;
    mc = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid_out) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("data_out", data_out, e.data);
          chk("frame_done", frame_done, e.last);
          chk("latency_cycle", cyc, e.cyc);
          last_data = e.data;
        end
      end else begin
        chk("frame_done_idle", frame_done, 0);
        chk("data_out_hold", data_out, last_data);
      end
    end
  end

  initial begin
    valid_in = 1'b0;
    clear    = 1'b0;
    data_in  = '0;
    rst_n    = 1'b1;
    #2;
    do_reset();

    ramp_pixels(W * H, 0);
    const_frame(-100);
    const_frame(-5000);
    const_frame(5000);
    ramp_pixels(W * H, 3);
    for (int i = 0; i < W * H; i++) send(int'($urandom), int'($urandom_range(0, 1)));

    ramp_pixels(20, 0);
    do_clear();
    ramp_pixels(W * H, 0);

    ramp_pixels(10, 0);
    do_clear();
    ramp_pixels(W * H, 1);

    ramp_pixels(37, 0);
    do_reset();
    ramp_pixels(W * H, 0);

    idle(5);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
